// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store request queue (lsq_fifo, ls_queue).
// Holds the controller state encoding, the dopc bit positions and a helper
// that packs the dopc field.
package lsq_pkg;

   // Controller states: accept requests (RUN) or wait for a terminate-marked
   // entry to leave the queue (DRAIN).
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } lsq_state_e;

   // dopc = {ls_valid, sel_ls, terminate}
   localparam int DOPC_W   = 3;
   localparam int LS_VALID = 2;
   localparam int SEL_LS   = 1;
   localparam int TERM     = 0;

   // Pack the operation code of a request.
   // ls_valid is the inverse of sel1: sel1 = 1 marks a non-LS request.
   function automatic logic [DOPC_W-1:0] make_dopc(input logic sel1,
                                                   input logic sel_ls,
                                                   input logic term);
      logic [DOPC_W-1:0] d;
      d           = '0;
      d[LS_VALID] = ~sel1;
      d[SEL_LS]   = sel_ls;
      d[TERM]     = term;
      return d;
   endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Storage and pointers for the load/store request queue.
// Plain circular buffer: DEPTH entries of W bits, power-of-two DEPTH so the
// pointers wrap naturally. The head entry reads as zero when empty.
// Pushes while full and pops while empty are ignored.
module lsq_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Head entry, forced to zero so an empty queue presents a clean bus.
   assign dout = empty ? '0 : mem[rd_ptr];

   // Entry storage: write the incoming entry at the write pointer.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; reset flushes regardless of pending traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ls_queue.sv
// Load/store request queue between the issue stage and data memory.
// Builds {dopc, addr} per request, queues it in lsq_fifo and presents the
// head entry to data memory one cycle after the push (no bypass).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready in the same cycle. Upstream:
// req_valid_i/req_ready_o (and only for sel_module_i == 3'b111; other
// requests are dropped without stalling). Downstream: dm_valid_o/dm_ready_i.
//
// A request marked terminate moves the controller to DRAIN, which closes the
// input until that entry has been taken by data memory.
//
// Optional macro LSQ_OVF_CHECK_EN: adds the sticky address-overflow flag
// ovf_o; without it ovf_o is tied low and no carry logic exists.
module ls_queue
   import lsq_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [2:0]               sel_module_i,
   input  logic [ADDR_W-1:0]        node_i,
   input  logic [ADDR_W-1:0]        opr1_i,
   input  logic [ADDR_W-1:0]        imm_i,
   input  logic                     mem_wen_i,
   input  logic                     sel1_i,
   input  logic                     sel_ls_i,
   input  logic                     terminate_i,
   output logic                     dm_valid_o,
   input  logic                     dm_ready_i,
   output logic [DOPC_W-1:0]        dm_dopc_o,
   output logic [ADDR_W-1:0]        dm_addr_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     ovf_o
);

   localparam int EW = ADDR_W + DOPC_W;

   lsq_state_e        state;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] agu_addr;
   logic [ADDR_W-1:0] push_addr;
   logic [EW-1:0]     push_entry;
   logic [EW-1:0]     head_entry;
   logic [DOPC_W-1:0] head_dopc;

   // Handshake qualification.
   assign req_ready_o = (state == RUN) & ~full;
   assign push        = req_valid_i & req_ready_o & (&sel_module_i);
   assign dm_valid_o  = ~empty;
   assign pop         = dm_valid_o & dm_ready_i;

   // Address generation: wrapped base + offset, optionally with carry watch.
`ifdef LSQ_OVF_CHECK_EN
   logic [ADDR_W:0] sum_ext;
   logic            ovf_q;

   assign sum_ext  = {1'b0, opr1_i} + {1'b0, imm_i};
   assign agu_addr = sum_ext[ADDR_W-1:0];
   assign ovf_o    = ovf_q;

   // Sticky overflow: set by any pushed base+offset that carries out.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (push && !mem_wen_i && sum_ext[ADDR_W]) begin
         ovf_q <= 1'b1;
      end
   end
`else
   assign agu_addr = opr1_i + imm_i;
   assign ovf_o    = 1'b0;
`endif

   assign push_addr  = mem_wen_i ? node_i : agu_addr;
   assign push_entry = {make_dopc(sel1_i, sel_ls_i, terminate_i), push_addr};

   lsq_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .count (count_o),
      .full  (full),
      .empty (empty)
   );

   assign head_dopc = head_entry[ADDR_W +: DOPC_W];
   assign dm_dopc_o = head_dopc;
   assign dm_addr_o = head_entry[ADDR_W-1:0];

   // Controller: close the input after a terminate push, reopen once the
   // terminate-marked entry has been popped. No pushes occur in DRAIN, so
   // the marked entry is the last one queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (push && terminate_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head_dopc[TERM]) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_queue.sv
// Bench for ls_queue (ADDR_W = 14, DEPTH = 4). Directed scenarios followed
// by randomized traffic. Expected entries come from a queue-level reference
// model; a monitor compares the presented head against the scoreboard.
// Builds with or without LSQ_OVF_CHECK_EN.
module tb_ls_queue;
   import lsq_pkg::*;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int EW     = ADDR_W + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [2:0]        sel_module_i;
   logic [ADDR_W-1:0] node_i;
   logic [ADDR_W-1:0] opr1_i;
   logic [ADDR_W-1:0] imm_i;
   logic              mem_wen_i;
   logic              sel1_i;
   logic              sel_ls_i;
   logic              terminate_i;
   logic              dm_valid_o;
   logic              dm_ready_i;
   logic [2:0]        dm_dopc_o;
   logic [ADDR_W-1:0] dm_addr_o;
   logic [CNT_W-1:0]  count_o;
   logic              ovf_o;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];    // scoreboard: entries expected at the head
   logic [EW-1:0] model_q[$];  // reference queue contents
   bit            model_drain;
   bit            model_ovf;

`ifdef LSQ_OVF_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   ls_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .sel_module_i (sel_module_i),
      .node_i       (node_i),
      .opr1_i       (opr1_i),
      .imm_i        (imm_i),
      .mem_wen_i    (mem_wen_i),
      .sel1_i       (sel1_i),
      .sel_ls_i     (sel_ls_i),
      .terminate_i  (terminate_i),
      .dm_valid_o   (dm_valid_o),
      .dm_ready_i   (dm_ready_i),
      .dm_dopc_o    (dm_dopc_o),
      .dm_addr_o    (dm_addr_o),
      .count_o      (count_o),
      .ovf_o        (ovf_o)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected entry for the request currently on the inputs.
   function automatic logic [EW-1:0] ref_entry();
      logic [31:0] a;
      if (mem_wen_i) a = 32'(node_i);
      else           a = (32'(opr1_i) + 32'(imm_i)) % (32'd1 << ADDR_W);
      return {~sel1_i, sel_ls_i, terminate_i, a[ADDR_W-1:0]};
   endfunction

   function automatic bit ref_carry();
      return (32'(opr1_i) + 32'(imm_i)) >= (32'd1 << ADDR_W);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      req_valid_i  = 1'b0;
      sel_module_i = 3'b111;
      node_i       = '0;
      opr1_i       = '0;
      imm_i        = '0;
      mem_wen_i    = 1'b0;
      sel1_i       = 1'b0;
      sel_ls_i     = 1'b0;
      terminate_i  = 1'b0;
   endtask

   task automatic set_req(input logic [ADDR_W-1:0] opr1, input logic [ADDR_W-1:0] imm,
                          input logic [ADDR_W-1:0] node, input logic wen, input logic sel1,
                          input logic sel_ls, input logic term);
      req_valid_i  = 1'b1;
      sel_module_i = 3'b111;
      opr1_i       = opr1;
      imm_i        = imm;
      node_i       = node;
      mem_wen_i    = wen;
      sel1_i       = sel1;
      sel_ls_i     = sel_ls;
      terminate_i  = term;
   endtask

   task automatic set_rand_req(input logic term);
      set_req(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), term);
   endtask

   // One clock: check per-cycle outputs mid-cycle against the model, then
   // advance the model on the rising edge. Returns 1 time unit after it.
   task automatic step();
      logic [EW-1:0] e;
      bit            acc;
      bit            pop_now;
      @(negedge clk);
      check("req_ready", 32'(req_ready_o), 32'(!model_drain && model_q.size() < DEPTH));
      check("dm_valid",  32'(dm_valid_o),  32'(model_q.size() != 0));
      check("count",     32'(count_o),     32'(model_q.size()));
      check("ovf",       32'(ovf_o),       32'(model_ovf));
      check("state",     32'(dut.state == DRAIN), 32'(model_drain));
      acc     = req_valid_i && (sel_module_i == 3'b111) && !model_drain && (model_q.size() < DEPTH);
      pop_now = dm_ready_i && (model_q.size() != 0);
      e       = ref_entry();
      @(posedge clk);
      if (rst) begin
         model_q.delete();
         exp_q.delete();
         model_drain = 1'b0;
         model_ovf   = 1'b0;
      end else begin
         if (pop_now) begin
            if (model_q[0][ADDR_W+TERM] && model_drain) model_drain = 1'b0;
            void'(model_q.pop_front());
         end
         if (acc) begin
            model_q.push_back(e);
            exp_q.push_back(e);
            if (terminate_i) model_drain = 1'b1;
            if (OVF_EN && !mem_wen_i && ref_carry()) model_ovf = 1'b1;
         end
      end
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (dm_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL head: dm_valid_o=1 but no entry expected (t=%0t)", $time);
            end else begin
               check("head_addr", 32'(dm_addr_o), 32'(exp_q[0][ADDR_W-1:0]));
               check("head_dopc", 32'(dm_dopc_o), 32'(exp_q[0][EW-1:ADDR_W]));
               if (dm_ready_i) void'(exp_q.pop_front());
            end
         end else begin
            check("empty_addr", 32'(dm_addr_o), 32'd0);
            check("empty_dopc", 32'(dm_dopc_o), 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      set_idle();
      dm_ready_i  = 1'b0;
      rst         = 1'b1;
      model_drain = 1'b0;
      model_ovf   = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_valid", 32'(dm_valid_o),  32'd0);
      check("rst_count", 32'(count_o),     32'd0);
      check("rst_addr",  32'(dm_addr_o),   32'd0);
      check("rst_dopc",  32'(dm_dopc_o),   32'd0);
      check("rst_ovf",   32'(ovf_o),       32'd0);

      // Base + offset load/store entry, one-cycle latency.
      set_req(14'h0100, 14'h0023, 14'h1555, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      set_idle();
      check("agu_valid", 32'(dm_valid_o), 32'd1);
      check("agu_addr",  32'(dm_addr_o),  32'h0123);
      check("agu_dopc",  32'(dm_dopc_o),  32'b110);
      dm_ready_i = 1'b1;
      step();
      dm_ready_i = 1'b0;

      // Node-address entry, then a request for another module.
      set_req(14'h0011, 14'h0022, 14'h2AAA, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      set_idle();
      check("node_addr", 32'(dm_addr_o), 32'h2AAA);
      check("node_dopc", 32'(dm_dopc_o), 32'b000);
      dm_ready_i = 1'b1;
      step();
      dm_ready_i = 1'b0;
      set_rand_req(1'b0);
      sel_module_i = 3'b011;
      step();
      set_idle();
      check("other_mod_count", 32'(count_o), 32'd0);
      check("other_mod_ready", 32'(req_ready_o), 32'd1);

      // Fill to full, refuse the fifth, no refill in the full cycle.
      for (int i = 0; i < 5; i++) begin
         set_rand_req(1'b0);
         step();
         if (i == 3) check("full_ready", 32'(req_ready_o), 32'd0);
      end
      check("full_count", 32'(count_o), 32'd4);
      set_rand_req(1'b0);
      dm_ready_i = 1'b1;
      step();
      check("no_refill_count", 32'(count_o), 32'd3);
      set_idle();
      for (int i = 0; i < 4; i++) step();
      check("drained_count", 32'(count_o), 32'd0);
      dm_ready_i = 1'b0;

      // Terminate entry behind two entries.
      set_rand_req(1'b0); step();
      set_rand_req(1'b0); step();
      set_rand_req(1'b1); step();
      set_rand_req(1'b0);
      check("term_ready0", 32'(req_ready_o), 32'd0);
      dm_ready_i = 1'b1;
      step();
      check("term_ready1", 32'(req_ready_o), 32'd0);
      step();
      check("term_ready2", 32'(req_ready_o), 32'd0);
      set_idle();
      step();
      check("term_ready3", 32'(req_ready_o), 32'd1);
      check("term_count",  32'(count_o),     32'd0);
      dm_ready_i = 1'b0;

      // Address wrap with overflow flag.
      set_req(14'h3FFF, 14'h0002, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_idle();
      check("wrap_addr", 32'(dm_addr_o), 32'h0001);
      check("wrap_ovf",  32'(ovf_o),     32'(OVF_EN));
      dm_ready_i = 1'b1;
      step();
      step();
      check("ovf_held", 32'(ovf_o), 32'(OVF_EN));
      dm_ready_i = 1'b0;

      // Reset with three entries queued while draining; reset beats push/pop.
      set_rand_req(1'b0); step();
      set_rand_req(1'b0); step();
      set_rand_req(1'b1); step();
      check("pre_rst_count", 32'(count_o), 32'd3);
      check("pre_rst_state", 32'(dut.state == DRAIN), 32'd1);
      rst        = 1'b1;
      dm_ready_i = 1'b1;
      set_rand_req(1'b0);
      step();
      rst = 1'b0;
      set_idle();
      dm_ready_i = 1'b0;
      check("post_rst_count", 32'(count_o),     32'd0);
      check("post_rst_valid", 32'(dm_valid_o),  32'd0);
      check("post_rst_ready", 32'(req_ready_o), 32'd1);
      check("post_rst_ovf",   32'(ovf_o),       32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         set_rand_req(1'($urandom_range(0, 15) == 0));
         req_valid_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) sel_module_i = 3'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) opr1_i = ADDR_W'($urandom_range(14'h3F00, 14'h3FFF));
         dm_ready_i = ($urandom_range(0, 2) != 0);
         rst        = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      set_idle();
      dm_ready_i = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, data-memory address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, request queue entries; power of two, 2 to 64.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid_i, input, 1: upstream request present.
REQ-006 The block SHALL have port req_ready_o, output, 1: queue accepts a request this cycle.
REQ-007 The block SHALL have port sel_module_i, input, 3: module select; request addressed to this unit only when 3'b111.
REQ-008 The block SHALL have ports node_i, opr1_i and imm_i, each input, ADDR_W: node address, base operand and offset.
REQ-009 The block SHALL have ports mem_wen_i, sel1_i, sel_ls_i and terminate_i, each input, 1: node-address select, write-not-LS, load/store select and terminate.
REQ-010 The block SHALL have port dm_valid_o, output, 1: head entry presented to data memory.
REQ-011 The block SHALL have port dm_ready_i, input, 1: data memory takes the head entry.
REQ-012 The block SHALL have port dm_dopc_o, output, 3: {ls_valid, sel_ls, terminate} of the head entry.
REQ-013 The block SHALL have port dm_addr_o, output, ADDR_W: address of the head entry.
REQ-014 The block SHALL have port count_o, output, clog2(DEPTH)+1: current occupancy.
REQ-015 The block SHALL have port ovf_o, output, 1: sticky address-overflow flag.

Function
REQ-016 Push SHALL occur when req_valid_i & req_ready_o & (&sel_module_i); a valid request with any other sel_module_i SHALL be dropped without stalling.
REQ-017 Entry fields SHALL be captured at push: dopc = {~sel1_i, sel_ls_i, terminate_i}; addr = mem_wen_i ? node_i : (opr1_i + imm_i) mod 2^ADDR_W.
REQ-018 Pop SHALL occur when dm_valid_o & dm_ready_i; dm_valid_o SHALL equal (count_o != 0).
REQ-019 dm_dopc_o and dm_addr_o SHALL show the head entry; they SHALL be 0 when the queue is empty.
REQ-020 Latency SHALL be one cycle: push at edge N into an empty queue gives dm_valid_o high after edge N; there SHALL be no combinational input-to-output bypass.
REQ-021 Order SHALL be FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-022 With push and pop in the same cycle and the queue neither full nor empty, count_o SHALL be unchanged and both pointers SHALL advance.
REQ-023 When count_o == DEPTH, req_ready_o SHALL be 0, including in a cycle where a pop occurs; there SHALL be no same-cycle refill.
REQ-024 A pop on an empty queue SHALL be impossible, because dm_valid_o is 0.
REQ-025 The FSM SHALL have states RUN and DRAIN; req_ready_o = (state == RUN) & ~full.
REQ-026 RUN SHALL transition to DRAIN on push of an entry with terminate_i = 1.
REQ-027 DRAIN SHALL transition to RUN in the cycle after the terminate-marked entry pops; while in DRAIN, entries ahead of it SHALL drain normally.

Reset
REQ-028 rst high at a clock edge SHALL flush the queue, zero both pointers and set state to RUN, regardless of in-flight entries.
REQ-029 After reset, outputs SHALL be: req_ready_o = 1, dm_valid_o = 0, dm_dopc_o = 0, dm_addr_o = 0, count_o = 0, ovf_o = 0.
REQ-030 Reset SHALL take priority over simultaneous push or pop in the same cycle.

Configuration
REQ-031 Macro LSQ_OVF_CHECK_EN, when defined, SHALL make ovf_o set on any push with mem_wen_i = 0 whose opr1_i + imm_i carries out of bit ADDR_W-1; ovf_o SHALL then hold until reset, and the wrapped address SHALL still be enqueued.
REQ-032 Without LSQ_OVF_CHECK_EN, ovf_o SHALL be tied to 0 and no carry logic SHALL be present.

Structure
REQ-033 Shared package lsq_pkg SHALL hold the FSM state encodings (RUN, DRAIN) and the dopc bit-position constants (LS_VALID = 2, SEL_LS = 1, TERM = 0).
REQ-034 Storage and pointers SHALL be a sub-module lsq_fifo (width ADDR_W+3, depth DEPTH); address generation, FSM and overflow logic SHALL reside in ls_queue.

Verification (ADDR_W = 14, DEPTH = 4)
REQ-035 Bench SHALL cover: push opr1 = 0x0100, imm = 0x0023, mem_wen = 0, sel1 = 0, sel_ls = 1 -> next cycle dm_valid_o = 1, dm_addr_o = 0x0123, dm_dopc_o = 3'b110.
REQ-036 Bench SHALL cover: mem_wen = 1, node = 0x2AAA, sel1 = 1 -> dm_addr_o = 0x2AAA, dm_dopc_o = 3'b000; a request with sel_module = 3'b011 -> count_o stays 0.
REQ-037 Bench SHALL cover: 5 pushes with dm_ready_i = 0 -> req_ready_o low after the 4th and the 5th is not accepted; a pop in the full cycle does not admit a push; drained order equals push order.
REQ-038 Bench SHALL cover: push a terminate entry behind 2 entries -> req_ready_o = 0 until the cycle after that entry pops, then returns to 1.
REQ-039 Bench SHALL cover, with LSQ_OVF_CHECK_EN: opr1 = 0x3FFF, imm = 0x0002 -> dm_addr_o = 0x0001 and ovf_o = 1, held until rst; without the macro, ovf_o = 0.
REQ-040 Bench SHALL cover: rst asserted with 3 entries queued and in DRAIN -> next cycle count_o = 0, dm_valid_o = 0, req_ready_o = 1.
